// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared state, requester id and burst constants for the RAM arbiter
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        ID_LD = 2'd0,
        ID_RD = 2'd1,
        ID_WR = 2'd2
    } req_id_t;

    localparam int BURST_MAX = 8;
    localparam int CNT_W     = $clog2(BURST_MAX);

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational winner select: loader first, then read/write round-robin
module ram_arb_pick
    import ram_arbiter_pkg::*;
(
    input  logic       ld_req,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic       ptr_wr,
    output logic       any,
    output logic [1:0] win
);

    // Loader always wins; a read/write tie is broken by the pointer.
    always_comb begin
        any = ld_req | rd_req | wr_req;
        win = ID_RD;
        if (ld_req) begin
            win = ID_LD;
        end else if (rd_req && wr_req) begin
            win = ptr_wr ? ID_WR : ID_RD;
        end else if (wr_req) begin
            win = ID_WR;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - three-way byte RAM burst arbiter; RAM_ARB_LOADER_EN enables the loader port
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [2:0]    ld_len,
    input  logic [63:0]   ld_wd,
    output logic          ld_gnt,
    output logic          ld_done,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    input  logic [2:0]    rd_len,
    output logic          rd_gnt,
    output logic          rd_done,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_len,
    input  logic [63:0]   wr_wd,
    output logic          wr_gnt,
    output logic          wr_done,
    output logic [7:0]    q_byte,
    output logic [2:0]    q_idx,
    output logic          q_vld,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wd,
    input  logic [7:0]    ram_d
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    req_id_t          owner;
    logic [AW-1:0]    base;
    logic [2:0]       len;
    logic [63:0]      word;
    logic             is_write;
    logic [CNT_W-1:0] cnt;
    logic             ptr_wr;
    logic             ld_req_eff;
    logic             any;
    logic [1:0]       win;
    logic             active;

`ifdef RAM_ARB_LOADER_EN
    assign ld_req_eff = ld_req;
`else
    logic unused_ld;
    assign ld_req_eff = 1'b0;
    assign unused_ld  = ld_req;
`endif

    ram_arb_pick u_pick (
        .ld_req (ld_req_eff),
        .rd_req (rd_req),
        .wr_req (wr_req),
        .ptr_wr (ptr_wr),
        .any    (any),
        .win    (win)
    );

    assign q_byte = ram_d;

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: IDLE -> BURST on any request, BURST until cnt reaches len, one DRAIN cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (any) state_nxt = ST_BURST;
            ST_BURST: if (cnt == len) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Burst context latched in IDLE, byte counter, round-robin pointer and read-return pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= ID_LD;
            base     <= '0;
            len      <= '0;
            word     <= '0;
            is_write <= 1'b0;
            cnt      <= '0;
            ptr_wr   <= 1'b0;
            q_vld    <= 1'b0;
            q_idx    <= '0;
        end else begin
            q_vld <= (state == ST_BURST) && !is_write;
            q_idx <= cnt;
            if (state == ST_IDLE && any) begin
                owner <= req_id_t'(win);
                cnt   <= '0;
                case (req_id_t'(win))
                    ID_LD: begin
                        base     <= ld_addr;
                        len      <= ld_len;
                        word     <= ld_wd;
                        is_write <= ld_we;
                    end
                    ID_WR: begin
                        base     <= wr_addr;
                        len      <= wr_len;
                        word     <= wr_wd;
                        is_write <= 1'b1;
                        ptr_wr   <= 1'b0;
                    end
                    default: begin
                        base     <= rd_addr;
                        len      <= rd_len;
                        word     <= '0;
                        is_write <= 1'b0;
                        ptr_wr   <= 1'b1;
                    end
                endcase
            end else if (state == ST_BURST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // RAM pins during BURST, grants from BURST through DRAIN, done in DRAIN.
    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_wd   = '0;
        active   = (state != ST_IDLE);
        if (state == ST_BURST) begin
            ram_addr = base + AW'(cnt);
            ram_we   = is_write;
            ram_wd   = word[{cnt, 3'b000} +: 8];
        end
        rd_gnt  = active && (owner == ID_RD);
        wr_gnt  = active && (owner == ID_WR);
        rd_done = (state == ST_DRAIN) && (owner == ID_RD);
        wr_done = (state == ST_DRAIN) && (owner == ID_WR);
        ld_gnt  = 1'b0;
        ld_done = 1'b0;
`ifdef RAM_ARB_LOADER_EN
        ld_gnt  = active && (owner == ID_LD);
        ld_done = (state == ST_DRAIN) && (owner == ID_LD);
`endif
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single byte-wide program/data RAM between three requesters: the boot/debug loader, the 64-bit read unit (fetch/POP/MOVRA), and the 64-bit write unit (PUSH/store). Each grant is one little-endian burst of 1–8 bytes at consecutive addresses. The block drives the RAM address, write-enable and write-data pins, and returns read bytes as an indexed byte stream. It sits between the datapath state sequencer and the RAM macro.

Parameters:
AW, 16, RAM address width; addresses wrap modulo 2^AW.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ld_req  in  1  loader request; held until ld_done
ld_we  in  1  loader burst is a write (1) or a read (0)
ld_addr  in  AW  loader start address
ld_len  in  3  loader burst length minus 1 (0 = 1 byte, 7 = 8 bytes)
ld_wd  in  64  loader write word; byte k = ld_wd[8k+7:8k]
ld_gnt  out  1  loader owns RAM
ld_done  out  1  one-cycle loader completion pulse
rd_req, rd_addr, rd_len  in  1/AW/3  read unit request, start address, length-1
rd_gnt, rd_done  out  1/1  read unit grant, completion pulse
wr_req, wr_addr, wr_len, wr_wd  in  1/AW/3/64  write unit request, start address, length-1, write word
wr_gnt, wr_done  out  1/1  write unit grant, completion pulse
q_byte  out  8  read data (direct pass of ram_d)
q_idx  out  3  byte index of q_byte within the burst
q_vld  out  1  q_byte is valid for the granted reader
ram_addr  out  AW  RAM address
ram_we  out  1  RAM write strobe
ram_wd  out  8  RAM write byte
ram_d  in  8  RAM read byte; valid one cycle after ram_addr

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, round-robin pointer favours the read unit. Reset during a burst abandons it: no done pulse, ram_we drops immediately.
- States and transitions:
  - IDLE: if any request is pending, latch the winner id, start address, len and write word; go to BURST with cnt=0.
  - BURST: each cycle, ram_addr = base+cnt (wraps), ram_we = is_write, ram_wd = word byte cnt. cnt increments each cycle; when cnt==len, go to DRAIN.
  - DRAIN: done pulse to the owner, then go to IDLE.
- Timing:
  - gnt is registered; it is high from the first BURST cycle through DRAIN inclusive.
  - A burst of N bytes occupies N BURST cycles plus 1 DRAIN cycle.
  - At least one IDLE cycle separates bursts.
- Arbitration:
  - Loader has fixed highest priority.
  - Read and write units alternate when both are pending. The pointer flips to the other unit after each read or write grant; loader grants leave it unchanged.
  - No preemption of a burst in progress.
- Read return: q_vld and q_idx are registered copies of (BURST and not is_write) and cnt, so they align with ram_d. The last q_vld coincides with DRAIN and done.
- Requester rules:
  - Inputs are sampled only in IDLE; changes during a burst are ignored.
  - A req still high in the IDLE cycle after done counts as a new request.
  - A req that drops before grant is simply not served.
- Wrap: with AW=16, address 0xFFFF+1 = 0x0000 within a burst.
- Write-type bursts never assert q_vld.

Optional Feature:
RAM_ARB_LOADER_EN
- Defined: loader port is arbitrated as specified above.
- Undefined: ld_* inputs are ignored, ld_gnt and ld_done are tied to 0, and arbitration is pure read/write round-robin.

Decomposition:
- The existing shared define include (alongside state and opcode codes) gains:
  - arbiter state codes (IDLE, BURST, DRAIN);
  - requester id codes (LD, RD, WR);
  - a BURST_MAX = 8 constant.
- One natural sub-module, ram_arb_pick: combinational priority/round-robin winner select from the three reqs plus the pointer. The registered pointer stays in the parent.

Test Plan:
- Read, rd_len=7 at 0x0100, RAM preloaded 0x11..0x88 → ram_addr 0x0100..0x0107 on consecutive cycles; q_vld for 8 cycles with q_idx 0..7 and q_byte 0x11..0x88; rd_done in the cycle of the q_idx=7 byte.
- Write, wr_len=2 at 0x0200, wr_wd=0x...00CCBBAA → ram_we for 3 cycles writing AA, BB, CC to 0x0200..0x0202; wr_done the next cycle; q_vld stays 0.
- rd_req and wr_req both held across two bursts → order RD, WR, RD; grants never overlap; one idle cycle between bursts.
- ld_req raised mid read burst with wr_req also pending → read burst completes, then loader granted before the write unit.
- Read at 0xFFFE, len=3 → ram_addr sequence FFFE, FFFF, 0000, 0001.
- rst_n low on the 3rd cycle of an 8-byte write → ram_we and gnt drop immediately with no done; after release, state is IDLE and a new rd_req is granted normally.
